// File: rtl/id_issue_buffer_pkg.sv
// Shared defaults and instruction field positions for the decode-stage issue buffer.
package id_issue_buffer_pkg;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_INSTR_W   = 32;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_REG_IDX_W = 5;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
endpackage

// File: rtl/id_issue_buffer_fwd_select.sv
// Priority forwarding match for one operand: lowest-index enabled source whose
// destination equals the operand index wins; a pending winner raises hazard.
module fwd_select
  import id_issue_buffer_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int REG_IDX_W = DEF_REG_IDX_W,
  parameter int NUM_FWD   = 3
) (
  input  logic [REG_IDX_W-1:0]         i_reg,
  input  logic [WORD_W-1:0]            i_rf_data,
  input  logic [NUM_FWD-1:0]           i_fwd_en,
  input  logic [NUM_FWD-1:0]           i_fwd_pend,
  input  logic [NUM_FWD*REG_IDX_W-1:0] i_fwd_reg,
  input  logic [NUM_FWD*WORD_W-1:0]    i_fwd_data,
  output logic [WORD_W-1:0]            o_data,
  output logic                         o_hazard
);

  logic w_found;

  always_comb begin
    o_data   = i_rf_data;
    o_hazard = 1'b0;
    w_found  = 1'b0;
    // x0 is hardwired zero, so it never forwards and never stalls
    if (i_reg != '0) begin
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (!w_found && i_fwd_en[k] && (i_fwd_reg[k*REG_IDX_W +: REG_IDX_W] == i_reg)) begin
          w_found  = 1'b1;
          o_data   = i_fwd_data[k*WORD_W +: WORD_W];
          o_hazard = i_fwd_pend[k];
        end
      end
    end
  end

endmodule

// File: rtl/id_issue_buffer.sv
// Decode-stage issue buffer: SKID_DEPTH-entry {pc, instr} FIFO between IF and EX
// with operand forwarding, load-use stall and a saturating hazard counter.
module id_issue_buffer
  import id_issue_buffer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int REG_IDX_W  = DEF_REG_IDX_W,
  parameter int NUM_FWD    = 3,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [ADDR_W-1:0]            i_pc,
  input  logic [INSTR_W-1:0]           i_instr,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [ADDR_W-1:0]            o_pc,
  output logic [INSTR_W-1:0]           o_instr,
  output logic [REG_IDX_W-1:0]         o_reg_a,
  output logic [REG_IDX_W-1:0]         o_reg_b,
  output logic [REG_IDX_W-1:0]         o_dest_reg,
  input  logic                         i_use_a,
  input  logic                         i_use_b,
  input  logic [WORD_W-1:0]            i_rf_data_a,
  input  logic [WORD_W-1:0]            i_rf_data_b,
  input  logic [NUM_FWD-1:0]           i_fwd_en,
  input  logic [NUM_FWD-1:0]           i_fwd_pend,
  input  logic [NUM_FWD*REG_IDX_W-1:0] i_fwd_reg,
  input  logic [NUM_FWD*WORD_W-1:0]    i_fwd_data,
  output logic [WORD_W-1:0]            o_data_a,
  output logic [WORD_W-1:0]            o_data_b,
  output logic                         o_hazard,
  output logic [$clog2(SKID_DEPTH):0]  o_count,
  output logic [CNT_W-1:0]             o_stall_cnt
);

  localparam int PTR_W    = $clog2(SKID_DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(SKID_DEPTH);

  logic [ADDR_W-1:0]   r_pc_mem    [SKID_DEPTH];
  logic [INSTR_W-1:0]  r_instr_mem [SKID_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_nonempty;
  logic                w_push;
  logic                w_pop;
  logic                w_haz_a;
  logic                w_haz_b;
  logic [INSTR_W-1:0]  w_head_instr;

  assign w_nonempty   = (r_count != '0);
  assign o_ready      = (r_count != DEPTH_C);
  assign w_push       = i_valid & o_ready;
  assign w_pop        = o_valid & i_ready;

  assign o_pc         = w_nonempty ? r_pc_mem[r_rd_ptr] : '0;
  assign w_head_instr = w_nonempty ? r_instr_mem[r_rd_ptr] : '0;
  assign o_instr      = w_head_instr;
  assign o_reg_a      = w_head_instr[RS1_LSB +: REG_IDX_W];
  assign o_reg_b      = w_head_instr[RS2_LSB +: REG_IDX_W];
  assign o_dest_reg   = w_head_instr[RD_LSB +: REG_IDX_W];

  fwd_select #(.WORD_W(WORD_W), .REG_IDX_W(REG_IDX_W), .NUM_FWD(NUM_FWD)) u_fwd_a (
    .i_reg      (o_reg_a),
    .i_rf_data  (i_rf_data_a),
    .i_fwd_en   (i_fwd_en),
    .i_fwd_pend (i_fwd_pend),
    .i_fwd_reg  (i_fwd_reg),
    .i_fwd_data (i_fwd_data),
    .o_data     (o_data_a),
    .o_hazard   (w_haz_a)
  );

  fwd_select #(.WORD_W(WORD_W), .REG_IDX_W(REG_IDX_W), .NUM_FWD(NUM_FWD)) u_fwd_b (
    .i_reg      (o_reg_b),
    .i_rf_data  (i_rf_data_b),
    .i_fwd_en   (i_fwd_en),
    .i_fwd_pend (i_fwd_pend),
    .i_fwd_reg  (i_fwd_reg),
    .i_fwd_data (i_fwd_data),
    .o_data     (o_data_b),
    .o_hazard   (w_haz_b)
  );

  assign o_hazard    = w_nonempty & ((i_use_a & w_haz_a) | (i_use_b & w_haz_b));
  assign o_valid     = w_nonempty & ~o_hazard;
  assign o_count     = r_count;
  assign o_stall_cnt = r_stall_cnt;

  // Entry storage carries no reset; a flushed or reset cycle never writes.
  always_ff @(posedge clk) begin
    if (!clr && !i_flush && w_push) begin
      r_pc_mem[r_wr_ptr]    <= i_pc;
      r_instr_mem[r_wr_ptr] <= i_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (o_hazard && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      // A pop in a flush cycle already handed its entry to EX; clearing covers it.
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_BITS'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed bench for id_issue_buffer: one task per scenario, inline comparisons.
module tb_id_issue_buffer;

  logic        clk;
  logic        clr;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [4:0]  o_reg_a;
  logic [4:0]  o_reg_b;
  logic [4:0]  o_dest_reg;
  logic        i_use_a;
  logic        i_use_b;
  logic [31:0] i_rf_data_a;
  logic [31:0] i_rf_data_b;
  logic [2:0]  i_fwd_en;
  logic [2:0]  i_fwd_pend;
  logic [14:0] i_fwd_reg;
  logic [95:0] i_fwd_data;
  logic [31:0] o_data_a;
  logic [31:0] o_data_b;
  logic        o_hazard;
  logic [1:0]  o_count;
  logic [15:0] o_stall_cnt;

  int errors = 0;
  int checks = 0;

  id_issue_buffer #(
    .ADDR_W(32), .INSTR_W(32), .WORD_W(32), .REG_IDX_W(5),
    .NUM_FWD(3), .SKID_DEPTH(2), .CNT_W(16)
  ) dut (
    .clk(clk), .clr(clr), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_instr(i_instr), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_instr(o_instr), .o_reg_a(o_reg_a), .o_reg_b(o_reg_b),
    .o_dest_reg(o_dest_reg), .i_use_a(i_use_a), .i_use_b(i_use_b),
    .i_rf_data_a(i_rf_data_a), .i_rf_data_b(i_rf_data_b), .i_fwd_en(i_fwd_en),
    .i_fwd_pend(i_fwd_pend), .i_fwd_reg(i_fwd_reg), .i_fwd_data(i_fwd_data),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_hazard(o_hazard),
    .o_count(o_count), .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_pc = '0; i_instr = '0; i_use_a = 1'b0; i_use_b = 1'b0;
    i_rf_data_a = '0; i_rf_data_b = '0;
    i_fwd_en = '0; i_fwd_pend = '0; i_fwd_reg = '0; i_fwd_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    i_valid = 1'b1; i_pc = pc; i_instr = instr;
    tick();
    i_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", o_ready); end
    checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %0b want 0", o_hazard); end
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
    checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", o_stall_cnt); end
    checks++; if (o_pc !== 32'd0 || o_instr !== 32'd0) begin errors++; $display("FAIL reset_head: got pc %h instr %h want 0 0", o_pc, o_instr); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    i_valid = 1'b1; i_pc = 32'h00; i_instr = mk(5'd1, 5'd2, 5'd3);
    tick();
    checks++; if (o_count !== 2'd1 || o_pc !== 32'h00 || o_valid !== 1'b1) begin errors++; $display("FAIL fill_first: got count %0d pc %h valid %0b want 1 00 1", o_count, o_pc, o_valid); end
    i_pc = 32'h04; i_instr = mk(5'd4, 5'd5, 5'd6);
    tick();
    checks++; if (o_count !== 2'd2 || o_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count %0d ready %0b want 2 0", o_count, o_ready); end
    i_pc = 32'h08; i_instr = mk(5'd7, 5'd8, 5'd9);
    tick();
    checks++; if (o_count !== 2'd2 || o_pc !== 32'h00) begin errors++; $display("FAIL fill_drop_when_full: got count %0d pc %h want 2 00", o_count, o_pc); end
    i_valid = 1'b0; i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready_ignores_pop: got %0b want 0", o_ready); end
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h00 || o_reg_a !== 5'd1 || o_reg_b !== 5'd2 || o_dest_reg !== 5'd3) begin errors++; $display("FAIL drain_head0: got v %0b pc %h a %0d b %0d d %0d want 1 00 1 2 3", o_valid, o_pc, o_reg_a, o_reg_b, o_dest_reg); end
    tick();
    checks++; if (o_pc !== 32'h04 || o_count !== 2'd1 || o_instr !== mk(5'd4, 5'd5, 5'd6)) begin errors++; $display("FAIL drain_head1: got pc %h count %0d instr %h want 04 1", o_pc, o_count, o_instr); end
    tick();
    checks++; if (o_count !== 2'd0 || o_valid !== 1'b0 || o_pc !== 32'h0) begin errors++; $display("FAIL drain_empty: got count %0d valid %0b pc %h want 0 0 0", o_count, o_valid, o_pc); end
    i_ready = 1'b0;
  endtask

  task automatic test_fwd_priority();
    do_reset();
    push_one(32'h10, mk(5'd5, 5'd6, 5'd1));
    i_use_a = 1'b1; i_rf_data_a = 32'h1111;
    i_fwd_en = 3'b011; i_fwd_reg = {5'd0, 5'd5, 5'd5};
    i_fwd_data = {32'h0, 32'hBBBB, 32'hAAAA};
    #1;
    checks++; if (o_data_a !== 32'hAAAA || o_hazard !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL fwd_prio0: got data %h haz %0b valid %0b want AAAA 0 1", o_data_a, o_hazard, o_valid); end
    i_fwd_en = 3'b010;
    #1;
    checks++; if (o_data_a !== 32'hBBBB) begin errors++; $display("FAIL fwd_src1: got %h want BBBB", o_data_a); end
    i_fwd_en = 3'b111; i_fwd_reg = {5'd5, 5'd9, 5'd9}; i_fwd_data = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    #1;
    checks++; if (o_data_a !== 32'hCCCC) begin errors++; $display("FAIL fwd_src2: got %h want CCCC", o_data_a); end
    i_fwd_en = 3'b011; i_fwd_reg = {5'd0, 5'd5, 5'd5}; i_fwd_pend = 3'b010;
    #1;
    checks++; if (o_data_a !== 32'hAAAA || o_hazard !== 1'b0) begin errors++; $display("FAIL fwd_pend_shadowed: got data %h haz %0b want AAAA 0", o_data_a, o_hazard); end
    i_fwd_en = 3'b000;
    #1;
    checks++; if (o_data_a !== 32'h1111) begin errors++; $display("FAIL fwd_none_rf: got %h want 1111", o_data_a); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    push_one(32'h20, mk(5'd2, 5'd7, 5'd3));
    i_use_b = 1'b1; i_rf_data_b = 32'h5555;
    i_fwd_en = 3'b001; i_fwd_pend = 3'b001; i_fwd_reg = {5'd0, 5'd0, 5'd7};
    #1;
    checks++; if (o_hazard !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL load_use_stall: got haz %0b valid %0b want 1 0", o_hazard, o_valid); end
    tick();
    checks++; if (o_stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt_1: got %0d want 1", o_stall_cnt); end
    tick();
    checks++; if (o_stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt_2: got %0d want 2", o_stall_cnt); end
    i_fwd_pend = 3'b000; i_fwd_data = {64'h0, 32'h1234};
    #1;
    checks++; if (o_data_b !== 32'h1234 || o_valid !== 1'b1 || o_hazard !== 1'b0) begin errors++; $display("FAIL load_use_resolved: got data %h valid %0b haz %0b want 1234 1 0", o_data_b, o_valid, o_hazard); end
    tick();
    checks++; if (o_stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt_hold: got %0d want 2", o_stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_x0_unused();
    do_reset();
    push_one(32'h30, mk(5'd0, 5'd9, 5'd4));
    i_use_a = 1'b1; i_rf_data_a = 32'hCAFE;
    i_fwd_en = 3'b011; i_fwd_pend = 3'b011; i_fwd_reg = {5'd0, 5'd9, 5'd0};
    i_fwd_data = {32'h0, 32'hDEAD, 32'hBEEF};
    #1;
    checks++; if (o_hazard !== 1'b0 || o_data_a !== 32'hCAFE) begin errors++; $display("FAIL x0_no_fwd: got haz %0b data %h want 0 CAFE", o_hazard, o_data_a); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL unused_b_no_hazard: got valid %0b want 1", o_valid); end
    i_use_b = 1'b1;
    #1;
    checks++; if (o_hazard !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL used_b_hazard: got haz %0b valid %0b want 1 0", o_hazard, o_valid); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    push_one(32'h20, mk(5'd1, 5'd1, 5'd1));
    push_one(32'h24, mk(5'd1, 5'd1, 5'd1));
    i_flush = 1'b1; i_valid = 1'b1; i_pc = 32'h40; i_instr = mk(5'd2, 5'd2, 5'd2);
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    #1;
    checks++; if (o_count !== 2'd0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_full: got count %0d valid %0b ready %0b want 0 0 1", o_count, o_valid, o_ready); end
    push_one(32'h28, mk(5'd1, 5'd1, 5'd1));
    i_flush = 1'b1; i_valid = 1'b1; i_pc = 32'h44;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    tick();
    checks++; if (o_count !== 2'd0 || o_valid !== 1'b0 || o_pc !== 32'h0) begin errors++; $display("FAIL flush_drops_push: got count %0d valid %0b pc %h want 0 0 0", o_count, o_valid, o_pc); end
    push_one(32'h2C, mk(5'd1, 5'd1, 5'd1));
    i_flush = 1'b1; i_ready = 1'b1;
    tick();
    i_flush = 1'b0; i_ready = 1'b0;
    #1;
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL flush_with_pop: got count %0d want 0", o_count); end
    push_one(32'h50, mk(5'd1, 5'd1, 5'd1));
    checks++; if (o_pc !== 32'h50 || o_count !== 2'd1) begin errors++; $display("FAIL after_flush_push: got pc %h count %0d want 50 1", o_pc, o_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset();
    push_one(32'h100, mk(5'd3, 5'd0, 5'd1));
    i_valid = 1'b1; i_ready = 1'b1; i_instr = mk(5'd3, 5'd0, 5'd1);
    for (int unsigned i = 0; i < 10; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      i_pc = exp_pc + 32'h4;
      #1;
      checks++; if (o_pc !== exp_pc || o_count !== 2'd1 || o_valid !== 1'b1) begin errors++; $display("FAIL wrap_issue_%0d: got pc %h count %0d valid %0b want %h 1 1", i, o_pc, o_count, o_valid, exp_pc); end
      tick();
    end
    i_valid = 1'b0;
    i_use_a = 1'b1; i_fwd_en = 3'b100; i_fwd_pend = 3'b100; i_fwd_reg = {5'd3, 5'd0, 5'd0};
    #1;
    checks++; if (o_pc !== 32'h128 || o_hazard !== 1'b1) begin errors++; $display("FAIL wrap_tail_stall: got pc %h haz %0b want 128 1", o_pc, o_hazard); end
    tick();
    tick();
    checks++; if (o_stall_cnt !== 16'd2 || o_count !== 2'd1) begin errors++; $display("FAIL wrap_stall_cnt: got stall %0d count %0d want 2 1", o_stall_cnt, o_count); end
    clr = 1'b1; i_valid = 1'b1; i_pc = 32'h200;
    tick();
    clr = 1'b0; i_valid = 1'b0;
    #1;
    checks++; if (o_count !== 2'd0 || o_stall_cnt !== 16'd0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL midstream_clr: got count %0d stall %0d ready %0b valid %0b want 0 0 1 0", o_count, o_stall_cnt, o_ready, o_valid); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_fwd_priority();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
